tile_pattern_gen: RTL and testbench



---
 rtl/tile_pattern_gen_pkg.sv | 36 +++
 rtl/tile_pattern_gen_timing.sv | 74 +++++++
 rtl/tile_pattern_gen.sv | 203 ++++++++++++++++++++
 tb/tb_tile_pattern_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// tile_pkg
// Shared constants and types for the tile pattern video source.
//   TMDS_ON / TMDS_OFF : DC-balanced data symbols for a fully lit / dark channel
//   CTL_00..CTL_11     : TMDS control symbols, index is {c1,c0} = {vsync,hsync}
//   rgb_t              : 3-bit on/off colour, {R,G,B}; bit n drives lane n
//   NUM_LANES / SYM_W  : lane count and symbol width of the TMDS output
// -----------------------------------------------------------------------------
package tile_pkg;

  localparam int NUM_LANES = 3;
  localparam int SYM_W     = 10;

  localparam logic [SYM_W-1:0] TMDS_ON  = 10'b1011110000;
  localparam logic [SYM_W-1:0] TMDS_OFF = 10'b0111110000;

  localparam logic [SYM_W-1:0] CTL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTL_11 = 10'b1010101011;

  typedef logic [2:0] rgb_t;

  // Lane 0 control symbol during blanking, selected by {vsync,hsync}.
  function automatic logic [SYM_W-1:0] ctl_sym(input logic vs, input logic hs);
    logic [SYM_W-1:0] s;
    case ({vs, hs})
      2'b00:   s = CTL_00;
      2'b01:   s = CTL_01;
      2'b10:   s = CTL_10;
      default: s = CTL_11;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tile_pattern_gen_timing.sv
// -----------------------------------------------------------------------------
// video_timing
// Horizontal/vertical raster counters for a VGA-style frame. Line and frame
// order is sync, back porch, active, front porch. All outputs are decoded
// combinationally from the current counter state; the caller registers them
// together with the pixel data so everything stays aligned.
//
// Ports:
//   clk_pix     in   pixel clock
//   resetn      in   asynchronous active-low reset (counters to hc=0, vc=0)
//   hsync       out  hc < H_SYNC (active high)
//   vsync       out  vc < V_SYNC (active high)
//   h_act       out  hc inside the horizontal active window
//   v_act       out  vc inside the vertical active window
//   line_end    out  last pixel of the line (hc wraps on the next edge)
//   frame_first out  hc == 0 and vc == 0
// -----------------------------------------------------------------------------
module video_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic clk_pix,
  input  logic resetn,
  output logic hsync,
  output logic vsync,
  output logic h_act,
  output logic v_act,
  output logic line_end,
  output logic frame_first
);

  localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HCW      = $clog2(H_TOTAL);
  localparam int VCW      = $clog2(V_TOTAL);
  localparam int H_ACT_LO = H_SYNC + H_BP;
  localparam int H_ACT_HI = H_ACT_LO + H_ACTIVE;
  localparam int V_ACT_LO = V_SYNC + V_BP;
  localparam int V_ACT_HI = V_ACT_LO + V_ACTIVE;

  logic [HCW-1:0] hc;
  logic [VCW-1:0] vc;
  logic           frame_end;

  assign line_end  = (hc == HCW'(H_TOTAL - 1));
  assign frame_end = (vc == VCW'(V_TOTAL - 1));

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      hc <= '0;
      vc <= '0;
    end else if (line_end) begin
      hc <= '0;
      vc <= frame_end ? '0 : vc + VCW'(1);
    end else begin
      hc <= hc + HCW'(1);
    end
  end

  // Window bounds can equal the total when a porch is zero, so compare at
  // 32 bits rather than truncating the bound to the counter width.
  assign hsync       = 32'(hc) < H_SYNC;
  assign vsync       = 32'(vc) < V_SYNC;
  assign h_act       = (32'(hc) >= H_ACT_LO) && (32'(hc) < H_ACT_HI);
  assign v_act       = (32'(vc) >= V_ACT_LO) && (32'(vc) < V_ACT_HI);
  assign frame_first = (hc == '0) && (vc == '0);

endmodule

// File: rtl/tile_pattern_gen.sv
// -----------------------------------------------------------------------------
// tile_pattern_gen
// Pixel-clock video source for the DVI-D path. Renders a writable
// BMP_W x BMP_H 1-bit bitmap, magnified by SCALE_X / SCALE_Y, in selectable
// foreground/background colours, and emits three TMDS symbols per pixel.
// Symbols, de and frame_start are registered one cycle after the raster
// state that produced them.
//
// Build option:
//   TILE_CHECKER_EN  when defined, the bitmap read is replaced by a
//                    checkerboard (bmp_x[0] ^ bmp_y[0]); the write port is
//                    still accepted but has no visible effect.
//
// Ports:
//   clk_pix      in   pixel clock
//   resetn       in   asynchronous active-low reset
//   wr_en        in   bitmap row write strobe
//   wr_row       in   row index to write (rows >= BMP_H are ignored)
//   wr_data      in   row bits, bit BMP_W-1 is the leftmost pixel
//   fg_rgb       in   foreground colour {R,G,B}
//   bg_rgb       in   background colour {R,G,B}
//   c0_symbol    out  blue / control TMDS symbol
//   c1_symbol    out  green TMDS symbol
//   c2_symbol    out  red TMDS symbol
//   frame_start  out  pulse for the hc=0, vc=0 pixel
//   de           out  data enable, aligned with the symbols
// -----------------------------------------------------------------------------
module tile_pattern_gen
  import tile_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BMP_W    = 32,
  parameter int BMP_H    = 32,
  parameter int SCALE_X  = 20,
  parameter int SCALE_Y  = 15
) (
  input  logic                     clk_pix,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [$clog2(BMP_H)-1:0] wr_row,
  input  logic [BMP_W-1:0]         wr_data,
  input  logic [2:0]               fg_rgb,
  input  logic [2:0]               bg_rgb,
  output logic [9:0]               c0_symbol,
  output logic [9:0]               c1_symbol,
  output logic [9:0]               c2_symbol,
  output logic                     frame_start,
  output logic                     de
);

  // bmp_x / bmp_y need one extra code for the saturated "outside" value.
  localparam int XW  = $clog2(BMP_W + 1);
  localparam int YW  = $clog2(BMP_H + 1);
  localparam int CW  = $clog2(BMP_W);
  localparam int RW  = $clog2(BMP_H);
  localparam int SXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int SYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

  // ---------------------------------------------------------------------------
  // Raster timing
  // ---------------------------------------------------------------------------
  logic hsync, vsync, h_act, v_act, line_end, frame_first, active;

  video_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk_pix     (clk_pix),
    .resetn      (resetn),
    .hsync       (hsync),
    .vsync       (vsync),
    .h_act       (h_act),
    .v_act       (v_act),
    .line_end    (line_end),
    .frame_first (frame_first)
  );

  assign active = h_act & v_act;

  // ---------------------------------------------------------------------------
  // Bitmap addressing: sub-pixel counters step the bitmap coordinate every
  // SCALE pixels/lines, so no divider is needed. Coordinates are held at 0
  // throughout blanking, which makes them 0 on the first active pixel/line.
  // ---------------------------------------------------------------------------
  logic [SXW-1:0] sub_x;
  logic [SYW-1:0] sub_y;
  logic [XW-1:0]  bmp_x;
  logic [YW-1:0]  bmp_y;
  logic           x_sat, y_sat, in_bmp;

  assign x_sat  = (bmp_x == XW'(BMP_W));
  assign y_sat  = (bmp_y == YW'(BMP_H));
  assign in_bmp = ~x_sat & ~y_sat;

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      sub_x <= '0;
      bmp_x <= '0;
    end else if (!h_act) begin
      sub_x <= '0;
      bmp_x <= '0;
    end else if (!x_sat) begin
      if (sub_x == SXW'(SCALE_X - 1)) begin
        sub_x <= '0;
        bmp_x <= bmp_x + XW'(1);
      end else begin
        sub_x <= sub_x + SXW'(1);
      end
    end
  end

  // Vertical coordinate advances once per active line, at its last pixel.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      sub_y <= '0;
      bmp_y <= '0;
    end else if (line_end) begin
      if (!v_act) begin
        sub_y <= '0;
        bmp_y <= '0;
      end else if (!y_sat) begin
        if (sub_y == SYW'(SCALE_Y - 1)) begin
          sub_y <= '0;
          bmp_y <= bmp_y + YW'(1);
        end else begin
          sub_y <= sub_y + SYW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel source
  // ---------------------------------------------------------------------------
  logic pix_bit;

`ifdef TILE_CHECKER_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_row, wr_data};
  assign pix_bit   = in_bmp & (bmp_x[0] ^ bmp_y[0]);
`else
  // Storage is deliberately not reset. The read is combinational from the
  // array state, so a write to the displayed row lands after this pixel's
  // symbol has been captured: same-cycle read returns the old row.
  logic [BMP_W-1:0] bitmap [BMP_H];
  logic [BMP_W-1:0] row_bits;
  logic [CW-1:0]    col_idx;

  always_ff @(posedge clk_pix) begin
    if (wr_en && (32'(wr_row) < BMP_H)) begin
      bitmap[wr_row] <= wr_data;
    end
  end

  // Out-of-range row/column codes only occur when saturated, and in_bmp
  // masks the result in that case.
  assign row_bits = bitmap[bmp_y[RW-1:0]];
  assign col_idx  = CW'(BMP_W - 1) - bmp_x[CW-1:0];
  assign pix_bit  = in_bmp & row_bits[col_idx];
`endif

  // ---------------------------------------------------------------------------
  // Symbol select per lane and output register
  // ---------------------------------------------------------------------------
  rgb_t                                 colour;
  logic [NUM_LANES-1:0][SYM_W-1:0] sym_d;
  logic [NUM_LANES-1:0][SYM_W-1:0] sym_q;

  assign colour = pix_bit ? rgb_t'(fg_rgb) : rgb_t'(bg_rgb);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    if (l == 0) begin : g_ctl
      assign sym_d[l] = active ? (colour[l] ? TMDS_ON : TMDS_OFF)
                               : ctl_sym(vsync, hsync);
    end else begin : g_dat
      assign sym_d[l] = active ? (colour[l] ? TMDS_ON : TMDS_OFF) : CTL_00;
    end
  end

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      sym_q       <= {NUM_LANES{CTL_00}};
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      sym_q       <= sym_d;
      de          <= active;
      frame_start <= frame_first;
    end
  end

  assign c0_symbol = sym_q[0];
  assign c1_symbol = sym_q[1];
  assign c2_symbol = sym_q[2];

endmodule

// File: tb/tb_tile_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_tile_pattern_gen
// Two instances with a shrunken raster: u_a has the magnified bitmap fitting
// inside the active window (bg margin right and below), u_b is clipped on
// both axes. A reference model derives every expected pixel from the raster
// position with plain division/modulo, pushes it into a per-instance queue at
// each clock edge, and a monitor pops and compares on the opposite edge.
// -----------------------------------------------------------------------------
module tb_tile_pattern_gen;
  import tile_pkg::*;

  localparam int HS = 4, HB = 3, HA = 40, HF = 3;
  localparam int VS = 2, VB = 3, VA = 30, VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int BW = 8, BH = 3;
  localparam int SXA = 4, SYA = 5;   // 32 x 15 inside 40 x 30
  localparam int SXB = 6, SYB = 11;  // 48 x 33 clipped to 40 x 30

  typedef struct packed {
    logic [9:0] c2;
    logic [9:0] c1;
    logic [9:0] c0;
    logic       de;
    logic       fs;
  } resp_t;

  localparam resp_t RST = '{c2: CTL_00, c1: CTL_00, c0: CTL_00, de: 1'b0, fs: 1'b0};

  logic          clk_pix = 1'b0;
  logic          resetn  = 1'b1;
  logic          wr_en   = 1'b0;
  logic [1:0]    wr_row  = '0;
  logic [BW-1:0] wr_data = '0;
  logic [2:0]    fg_rgb  = 3'b110;
  logic [2:0]    bg_rgb  = 3'b101;

  logic [9:0] c0_a, c1_a, c2_a, c0_b, c1_b, c2_b;
  logic       fs_a, de_a, fs_b, de_b;

  always #5 clk_pix = ~clk_pix;

  tile_pattern_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .BMP_W (BW), .BMP_H (BH), .SCALE_X (SXA), .SCALE_Y (SYA)
  ) u_a (
    .clk_pix (clk_pix), .resetn (resetn), .wr_en (wr_en), .wr_row (wr_row),
    .wr_data (wr_data), .fg_rgb (fg_rgb), .bg_rgb (bg_rgb),
    .c0_symbol (c0_a), .c1_symbol (c1_a), .c2_symbol (c2_a),
    .frame_start (fs_a), .de (de_a)
  );

  tile_pattern_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .BMP_W (BW), .BMP_H (BH), .SCALE_X (SXB), .SCALE_Y (SYB)
  ) u_b (
    .clk_pix (clk_pix), .resetn (resetn), .wr_en (wr_en), .wr_row (wr_row),
    .wr_data (wr_data), .fg_rgb (fg_rgb), .bg_rgb (bg_rgb),
    .c0_symbol (c0_b), .c1_symbol (c1_b), .c2_symbol (c2_b),
    .frame_start (fs_b), .de (de_b)
  );

  int checks = 0;
  int errors = 0;
  int t      = 0;  // raster states since reset release == hc/vc now held by DUT

  logic [BW-1:0] mbmp [BH];
  resp_t q_a[$];
  resp_t q_b[$];

  task automatic cmp(input string nm, input resp_t exp, input resp_t act);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got c2=%b c1=%b c0=%b de=%b fs=%b, want c2=%b c1=%b c0=%b de=%b fs=%b",
               nm, $time, act.c2, act.c1, act.c0, act.de, act.fs,
               exp.c2, exp.c1, exp.c0, exp.de, exp.fs);
    end
  endtask

  task automatic cmp_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  // Expected output for raster state tt, derived directly from the frame
  // geometry and the current bitmap/colour inputs.
  function automatic resp_t expect_at(input int tt, input int sx, input int sy);
    resp_t r;
    int hc, vc, bx, by;
    logic hs, vs, act, pix;
    logic [2:0] col;
    hc  = tt % HT;
    vc  = (tt / HT) % VT;
    hs  = (hc < HS);
    vs  = (vc < VS);
    act = (hc >= HS + HB) && (hc < HS + HB + HA) && (vc >= VS + VB) && (vc < VS + VB + VA);
    r.fs = (hc == 0) && (vc == 0);
    r.de = act;
    if (act) begin
      bx  = (hc - HS - HB) / sx;
      by  = (vc - VS - VB) / sy;
      pix = 1'b0;
      if (bx < BW && by < BH) begin
`ifdef TILE_CHECKER_EN
        pix = ((bx + by) % 2) == 1;
`else
        pix = mbmp[by][BW - 1 - bx];
`endif
      end
      col  = pix ? fg_rgb : bg_rgb;
      r.c0 = col[0] ? TMDS_ON : TMDS_OFF;
      r.c1 = col[1] ? TMDS_ON : TMDS_OFF;
      r.c2 = col[2] ? TMDS_ON : TMDS_OFF;
    end else begin
      r.c1 = CTL_00;
      r.c2 = CTL_00;
      if (vs && hs)      r.c0 = CTL_11;
      else if (vs)       r.c0 = CTL_10;
      else if (hs)       r.c0 = CTL_01;
      else               r.c0 = CTL_00;
    end
    return r;
  endfunction

  // Reference model: at each edge predict what the DUTs register, then apply
  // the write that the same edge performs (so same-cycle reads see old data).
  initial forever begin
    @(posedge clk_pix);
    if (!resetn) begin
      q_a.push_back(RST);
      q_b.push_back(RST);
      t = 0;
    end else begin
      q_a.push_back(expect_at(t, SXA, SYA));
      q_b.push_back(expect_at(t, SXB, SYB));
      t++;
    end
    if (wr_en && int'(wr_row) < BH) mbmp[wr_row] = wr_data;
  end

  // Monitor: compare on the falling edge, plus frame-level counts on u_a.
  int since_fs = 0;
  int de_cnt   = 0;
  bit fs_seen  = 1'b0;
  initial forever begin
    @(negedge clk_pix);
    if (q_a.size() > 0) cmp("pix_a", q_a.pop_front(), resp_t'({c2_a, c1_a, c0_a, de_a, fs_a}));
    if (q_b.size() > 0) cmp("pix_b", q_b.pop_front(), resp_t'({c2_b, c1_b, c0_b, de_b, fs_b}));
    if (!resetn) begin
      fs_seen = 1'b0;
    end else begin
      if (fs_a) begin
        if (fs_seen) begin
          cmp_int("frame_period", since_fs, HT * VT);
          cmp_int("de_per_frame", de_cnt, HA * VA);
        end
        fs_seen  = 1'b1;
        since_fs = 0;
        de_cnt   = 0;
      end
      since_fs++;
      if (de_a) de_cnt++;
    end
  end

  task automatic drive_random();
    wr_en   = ($urandom_range(0, 3) == 0);
    wr_row  = 2'($urandom_range(0, 3));  // row 3 is out of range and ignored
    wr_data = BW'($urandom);
    if ($urandom_range(0, 63) == 0) begin
      fg_rgb = 3'($urandom);
      bg_rgb = ($urandom_range(0, 1) == 0) ? ~fg_rgb : 3'($urandom);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk_pix);
      drive_random();
    end
  endtask

  initial begin
    int guard;
    #1 resetn = 1'b0;
    // Load every row while held in reset; storage is not reset.
    for (int r = 0; r < BH; r++) begin
      @(negedge clk_pix);
      wr_en   = 1'b1;
      wr_row  = 2'(r);
      wr_data = BW'($urandom);
    end
    @(negedge clk_pix);
    wr_en = 1'b0;
    repeat (3) @(negedge clk_pix);
    #2 resetn = 1'b1;

    run_cycles(HT * VT + 10);

    // Reset in the middle of an active line of the second frame.
    guard = 0;
    while (!(((t % HT) == 20) && (((t / HT) % VT) == 15)) && guard < 3 * HT * VT) begin
      @(negedge clk_pix);
      drive_random();
      guard++;
    end
    cmp_int("mid_frame_wait_timeout", int'(guard >= 3 * HT * VT), 0);
    wr_en = 1'b0;
    #2 resetn = 1'b0;
    #1;
    cmp("async_rst_a", RST, resp_t'({c2_a, c1_a, c0_a, de_a, fs_a}));
    cmp("async_rst_b", RST, resp_t'({c2_b, c1_b, c0_b, de_b, fs_b}));
    repeat (3) @(negedge clk_pix);
    #2 resetn = 1'b1;

    run_cycles(2 * HT * VT + 50);
    wr_en = 1'b0;
    repeat (2) @(negedge clk_pix);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
